mem_bus_ctrl: RTL and testbench
===============================

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 Parameter ADDR_BITS, default 15: address width, matching the RAM.
REQ-002 Parameter DATA_BITS, default 8: data width, matching the RAM.
REQ-003 Parameter WAIT_CYCLES, default 2, legal range 0..15: extra RAM access cycles before data is sampled or the write strobe is issued.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port req_valid, input, 1 bit: the requester presents a transaction.
REQ-007 Port req_ready, output, 1 bit: the controller can accept a transaction.
REQ-008 Port req_we, input, 1 bit: 1 means write, 0 means read.
REQ-009 Port req_addr, input, ADDR_BITS: transaction address.
REQ-010 Port req_wdata, input, DATA_BITS: write data.
REQ-011 Port resp_valid, output, 1 bit: transaction completed; held until consumed.
REQ-012 Port resp_ready, input, 1 bit: the requester consumes the response.
REQ-013 Port resp_rdata, output, DATA_BITS: data from the last completed read.
REQ-014 Port ram_a, output, ADDR_BITS: RAM address.
REQ-015 Port ram_d, output, DATA_BITS: RAM write data.
REQ-016 Port ram_q, input, DATA_BITS: RAM read data; combinational, X when ram_rd is low.
REQ-017 Port ram_rd, output, 1 bit: RAM read enable.
REQ-018 Port ram_wr, output, 1 bit: RAM write enable; the RAM writes on the rising clk edge while ram_wr is high.

Function
REQ-019 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-020 req_ready SHALL be 1 only in IDLE.
REQ-021 A handshake SHALL occur on an edge where req_valid and req_ready are both 1; that edge latches req_we, req_addr and req_wdata, loads the wait counter with WAIT_CYCLES and moves to ACCESS.
REQ-022 In ACCESS, ram_a and ram_d SHALL drive the latched address and data, and SHALL stay stable for the whole of ACCESS.
REQ-023 In ACCESS, the wait counter SHALL decrement each cycle while it is nonzero.
REQ-024 ACCESS SHALL therefore last exactly WAIT_CYCLES+1 cycles; the cycle with counter==0 is the final cycle.
REQ-025 For a read, ram_rd SHALL be 1 for every ACCESS cycle.
REQ-026 For a read, resp_rdata SHALL load ram_q at the edge ending the final ACCESS cycle.
REQ-027 For a write, ram_wr SHALL be 1 only in the final ACCESS cycle, so exactly one write edge occurs per write transaction.
REQ-028 For a write, resp_rdata SHALL keep its previous value.
REQ-029 ram_rd and ram_wr SHALL be 0 in IDLE and RESP, and SHALL never both be 1.
REQ-030 The edge ending the final ACCESS cycle SHALL move to RESP.
REQ-031 In RESP, resp_valid SHALL be 1; the move to IDLE SHALL occur on the first edge where resp_ready is 1.
REQ-032 Latency: for a handshake at edge N, resp_valid SHALL first be 1 in the cycle after edge N+WAIT_CYCLES+1.
REQ-033 A request presented while the controller is busy SHALL wait, unaccepted, until IDLE.
REQ-034 Back-to-back transactions: the earliest next acceptance is the edge after leaving RESP, one idle cycle minimum.
REQ-035 With WAIT_CYCLES=0, ACCESS SHALL last exactly one cycle.
REQ-036 The wait counter SHALL be 4 bits wide and SHALL never wrap.

Reset
REQ-037 While rst=1, the controller SHALL force ram_wr=0 and ram_rd=0 combinationally, so a reset mid-ACCESS never completes a write.
REQ-038 At an edge with rst=1, the state SHALL become IDLE, the counter 0, resp_rdata 0 and the latched address and data 0.
REQ-039 After reset, req_ready SHALL be 1 and resp_valid 0.
REQ-040 A transaction in flight at reset SHALL be abandoned with no response.

Structure
REQ-041 A shared package mem_bus_pkg SHALL hold the state type (IDLE, ACCESS, RESP) and the default values of ADDR_BITS, DATA_BITS and WAIT_CYCLES.
REQ-042 The wait-state counter SHALL be the single sub-module wait_timer, with load, count-down and a zero flag.

Verification
REQ-043 Write 0x12 to address 0x0100, then read 0x0100, with WAIT_CYCLES=2 -> exactly one ram_wr cycle; read resp_rdata=0x12; resp_valid rises 4 cycles after each handshake.
REQ-044 WAIT_CYCLES=0: write 0xA5 to 0x7FFF, then read it -> resp_rdata=0xA5; ACCESS lasts 1 cycle.
REQ-045 Hold resp_ready=0 for 5 cycles after completion -> resp_valid and resp_rdata held stable; req_ready stays 0 throughout.
REQ-046 Assert rst in the final ACCESS cycle of a write of 0x55 to 0x0010 -> ram_wr=0 in that cycle; a later read of 0x0010 returns its old value; no response is issued.
REQ-047 req_valid held high for 3 consecutive reads -> each handshake occurs only in IDLE; data returns in order; ram_rd and ram_wr are never 1 together.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types and default geometry for the memory bus controller.
package mem_bus_pkg;
    localparam int ADDR_BITS_DEF   = 15;
    localparam int DATA_BITS_DEF   = 8;
    localparam int WAIT_CYCLES_DEF = 2;
    localparam int CNT_BITS        = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;
endpackage

// File: rtl/wait_timer.sv
// Wait-state down-counter: load on accept, count down to zero and hold there.
module wait_timer import mem_bus_pkg::*; (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [CNT_BITS-1:0] load_val,
    input  logic                en,
    output logic                zero
);
    logic [CNT_BITS-1:0] count;

    // Saturates at zero so it can never wrap.
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en && count != '0)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);
endmodule

// File: rtl/mem_bus_ctrl.sv
// Single-outstanding request/response bridge onto an asynchronous-read SRAM
// with a programmable number of wait states.
module mem_bus_ctrl import mem_bus_pkg::*; #(
    parameter int ADDR_BITS   = ADDR_BITS_DEF,
    parameter int DATA_BITS   = DATA_BITS_DEF,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [DATA_BITS-1:0] req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [DATA_BITS-1:0] resp_rdata,
    output logic [ADDR_BITS-1:0] ram_a,
    output logic [DATA_BITS-1:0] ram_d,
    input  logic [DATA_BITS-1:0] ram_q,
    output logic                 ram_rd,
    output logic                 ram_wr
);
    state_t               state;
    logic                 we_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [DATA_BITS-1:0] wdata_q;
    logic [DATA_BITS-1:0] rdata_q;
    logic                 accept;
    logic                 cnt_zero;

    assign accept = req_valid && (state == IDLE);

    wait_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (CNT_BITS'(WAIT_CYCLES)),
        .en       (state == ACCESS),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    we_q    <= req_we;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    state   <= ACCESS;
                end
                ACCESS: if (cnt_zero) begin
                    if (!we_q) rdata_q <= ram_q;
                    state <= RESP;
                end
                RESP: if (resp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_rdata = rdata_q;
    assign ram_a      = addr_q;
    assign ram_d      = wdata_q;

    // Strobes are gated by rst directly so a reset in the final cycle cannot land a write.
    assign ram_rd = !rst && (state == ACCESS) && !we_q;
    assign ram_wr = !rst && (state == ACCESS) && we_q && cnt_zero;
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: two instances (2 and 0 wait states) against SRAM models
// and a transaction-level reference memory.
module tb_mem_bus_ctrl;
    localparam int AW = 15;
    localparam int DW = 8;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst [2];
    logic          req_valid [2], req_ready [2], req_we [2];
    logic          resp_valid [2], resp_ready [2];
    logic          ram_rd [2], ram_wr [2];
    logic [AW-1:0] req_addr [2], ram_a [2];
    logic [DW-1:0] req_wdata [2], resp_rdata [2], ram_d [2], ram_q [2];

    logic [DW-1:0] mem [2][DEPTH];
    logic [DW-1:0] ref_mem [2][DEPTH];
    logic [DW-1:0] last_rd [2];
    int            wr_edges [2] = '{0, 0};
    int            n_chk = 0;
    int            n_fail = 0;

    function automatic int wc(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    mem_bus_ctrl #(.ADDR_BITS(AW), .DATA_BITS(DW), .WAIT_CYCLES(2)) u_dut0 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
        .ram_a(ram_a[0]), .ram_d(ram_d[0]), .ram_q(ram_q[0]), .ram_rd(ram_rd[0]), .ram_wr(ram_wr[0])
    );

    mem_bus_ctrl #(.ADDR_BITS(AW), .DATA_BITS(DW), .WAIT_CYCLES(0)) u_dut1 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
        .ram_a(ram_a[1]), .ram_d(ram_d[1]), .ram_q(ram_q[1]), .ram_rd(ram_rd[1]), .ram_wr(ram_wr[1])
    );

    // SRAM models: combinational read, write on the rising edge.
    assign ram_q[0] = ram_rd[0] ? mem[0][ram_a[0]] : 'x;
    assign ram_q[1] = ram_rd[1] ? mem[1][ram_a[1]] : 'x;

    always @(posedge clk) begin
        if (ram_wr[0]) begin
            mem[0][ram_a[0]] <= ram_d[0];
            wr_edges[0] <= wr_edges[0] + 1;
        end
        if (ram_wr[1]) begin
            mem[1][ram_a[1]] <= ram_d[1];
            wr_edges[1] <= wr_edges[1] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++)
            if (ram_rd[k] || ram_wr[k]) chk("rd_wr_exclusive", 32'(ram_rd[k] && ram_wr[k]), 32'd0);
    end

    // One transaction, called at a negedge while idle; keep leaves req_valid asserted.
    task automatic txn(input int k, input bit we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input int hold, input bit keep);
        int cyc, lat, rd_cyc, wr_cyc, w0;
        req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = a; req_wdata[k] = d;
        cyc = 0;
        while (!req_ready[k] && cyc < 50) begin @(negedge clk); cyc++; end
        chk("accept", 32'(req_ready[k]), 32'd1);
        w0 = wr_edges[k];
        @(negedge clk);
        if (!keep) req_valid[k] = 1'b0;
        if (we) ref_mem[k][a] = d;
        else    last_rd[k] = ref_mem[k][a];
        lat = 1; rd_cyc = 0; wr_cyc = 0;
        while (!resp_valid[k] && lat < 50) begin
            chk("busy_ready", 32'(req_ready[k]), 32'd0);
            chk("ram_a", 32'(ram_a[k]), 32'(a));
            if (we) chk("ram_d", 32'(ram_d[k]), 32'(d));
            if (ram_wr[k]) chk("wr_final_cycle", 32'(lat), 32'(wc(k) + 1));
            rd_cyc += int'(ram_rd[k]);
            wr_cyc += int'(ram_wr[k]);
            @(negedge clk); lat++;
        end
        chk("latency", 32'(lat), 32'(wc(k) + 2));
        chk("rd_cycles", 32'(rd_cyc), we ? 32'd0 : 32'(wc(k) + 1));
        chk("wr_cycles", 32'(wr_cyc), we ? 32'd1 : 32'd0);
        chk("wr_edges", 32'(wr_edges[k] - w0), we ? 32'd1 : 32'd0);
        chk("resp_strobes", 32'({ram_rd[k], ram_wr[k]}), 32'd0);
        chk("rdata", 32'(resp_rdata[k]), 32'(last_rd[k]));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(resp_valid[k]), 32'd1);
            chk("hold_rdata", 32'(resp_rdata[k]), 32'(last_rd[k]));
            chk("hold_ready", 32'(req_ready[k]), 32'd0);
        end
        resp_ready[k] = 1'b1;
        @(negedge clk);
        resp_ready[k] = 1'b0;
        chk("released", 32'(resp_valid[k]), 32'd0);
        chk("idle_ready", 32'(req_ready[k]), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[k][i] = DW'($urandom);
                ref_mem[k][i] = mem[k][i];
            end
            rst[k] = 1'b1; req_valid[k] = 1'b0; req_we[k] = 1'b0;
            req_addr[k] = '0; req_wdata[k] = '0; resp_ready[k] = 1'b0;
            last_rd[k] = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_strobes", 32'({ram_rd[k], ram_wr[k]}), 32'd0);
            rst[k] = 1'b0;
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_req_ready", 32'(req_ready[k]), 32'd1);
            chk("rst_resp_valid", 32'(resp_valid[k]), 32'd0);
            chk("rst_rdata", 32'(resp_rdata[k]), 32'd0);
        end

        // Write then read back, 2 wait states; then a held response.
        txn(0, 1'b1, 15'h0100, 8'h12, 0, 1'b0);
        txn(0, 1'b0, 15'h0100, 8'h00, 0, 1'b0);
        chk("rd_0100", 32'(resp_rdata[0]), 32'h12);
        txn(0, 1'b0, 15'h0100, 8'h00, 5, 1'b0);

        // Zero wait states at the top address.
        txn(1, 1'b1, 15'h7FFF, 8'hA5, 0, 1'b0);
        txn(1, 1'b0, 15'h7FFF, 8'h00, 0, 1'b0);
        chk("rd_7fff", 32'(resp_rdata[1]), 32'hA5);

        // Reset lands in the final cycle of a write: the write must not happen.
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 15'h0010; req_wdata[0] = 8'h55;
        @(negedge clk);
        req_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_wr", 32'(ram_wr[0]), 32'd1);
        rst[0] = 1'b1;
        #1;
        chk("rst_kills_wr", 32'(ram_wr[0]), 32'd0);
        w0 = wr_edges[0];
        @(negedge clk);
        rst[0] = 1'b0;
        last_rd[0] = '0;
        chk("rst_no_edge", 32'(wr_edges[0] - w0), 32'd0);
        chk("rst2_req_ready", 32'(req_ready[0]), 32'd1);
        chk("rst2_rdata", 32'(resp_rdata[0]), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("no_resp_after_rst", 32'(resp_valid[0]), 32'd0);
        end
        txn(0, 1'b0, 15'h0010, 8'h00, 0, 1'b0);
        chk("old_0010", 32'(resp_rdata[0]), 32'(ref_mem[0][15'h0010]));

        // req_valid held through three reads.
        txn(0, 1'b0, 15'h0100, 8'h00, 0, 1'b1);
        txn(0, 1'b0, 15'h7FFF, 8'h00, 0, 1'b1);
        txn(0, 1'b0, 15'h0010, 8'h00, 1, 1'b0);

        // Randomized traffic over a small address pool so reads hit earlier writes.
        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 30; n++) begin
                bit keep;
                keep = ($urandom_range(0, 3) == 0);
                txn(k, 1'(($urandom & 1)), AW'($urandom_range(0, 7) * 1111),
                    DW'($urandom), $urandom_range(0, 3), keep);
                if (!keep && $urandom_range(0, 2) == 0)
                    repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            req_valid[k] = 1'b0;
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
